// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator controller and datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
//
// Contents: FSM state encoding, R field width, R validation helpers.
package cic_pkg;

  localparam int R_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_BND = 2'd1,
    FLUSH    = 2'd2,
    WARM     = 2'd3
  } ctrl_state_e;

  // Legal decimation factors are the powers of two 1..16.
  function automatic logic is_valid_r(input logic [R_W-1:0] r);
    return (r != '0) && ((r & (r - R_W'(1))) == '0) && (r <= R_W'(16));
  endfunction

  // Bit position of the set bit of a legal R (0..4).
  function automatic logic [2:0] log2_r(input logic [R_W-1:0] r);
    logic [2:0] l;
    l = '0;
    for (int i = 0; i < R_W; i++) begin
      if (r[i]) l = 3'(i);
    end
    return l;
  endfunction

endpackage

// File: rtl/cic_strobe_gen.sv
// Input-sample and decimated-output strobe generator for the CIC.
// Latency: strobes are combinational from the counters; counters update each clk.
// Backpressure: none; hold/clear come from the controller FSM.
//
// Ports: clk, rst_n (async, active low); hold freezes the clock divider at 0
// and blocks in_stb; clear zeroes the phase counter; r is the applied R;
// out_en gates out_stb; in_stb/out_stb are the generated strobes.
module cic_strobe_gen
  import cic_pkg::*;
#(
  parameter int CLK_DIV = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hold,
  input  logic           clear,
  input  logic [R_W-1:0] r,
  input  logic           out_en,
  output logic           in_stb,
  output logic           out_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [R_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic             div_last, ph_last;

  assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  // r only changes while clear is asserted, so ph_cnt never overshoots r-1.
  assign ph_last  = (ph_cnt_q == r - R_W'(1));
  assign in_stb   = div_last && !hold;
  assign out_stb  = in_stb && ph_last && out_en;

  always_comb begin
    div_cnt_d = div_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    if (hold || div_last) div_cnt_d = '0;
    else                  div_cnt_d = div_cnt_q + DIV_W'(1);
    if (clear)       ph_cnt_d = '0;
    else if (in_stb) ph_cnt_d = ph_last ? '0 : ph_cnt_q + R_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      ph_cnt_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencer for the CIC decimator: strobes plus glitch-free runtime R changes.
// Latency: cfg_err 1 clk after handshake; R change applied at the next output boundary.
// Backpressure: cfg_ready low outside RUN; requester holds cfg_valid/cfg_r until accepted.
//
// Ports: clk, rst_n (async, active low); cfg_valid/cfg_r/cfg_ready request
// port; cfg_err rejection pulse; cic_r applied R; cic_rst_n datapath flush
// (active low); in_stb/out_stb datapath strobes; busy = not in RUN;
// err_cnt saturating reject count.
// Build option: define CIC_CTRL_ERR_CNT_EN to enable err_cnt (else tied to 0).
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int CLK_DIV   = 3,
  parameter int FLUSH_LEN = 8,
  parameter int Q         = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  input  logic [R_W-1:0] cfg_r,
  output logic           cfg_ready,
  output logic           cfg_err,
  output logic [R_W-1:0] cic_r,
  output logic           cic_rst_n,
  output logic           in_stb,
  output logic           out_stb,
  output logic           busy,
  output logic [7:0]     err_cnt
);

  ctrl_state_e    state_q, state_d;
  logic [R_W-1:0] cic_r_q, cic_r_d;
  logic [R_W-1:0] pend_r_q, pend_r_d;
  logic [7:0]     flush_cnt_q, flush_cnt_d;
  logic [7:0]     warm_cnt_q, warm_cnt_d;
  logic           cfg_err_q, cfg_err_d;
  logic [7:0]     warm_last;
  logic           in_flush, out_en;

  assign in_flush  = (state_q == FLUSH);
  assign out_en    = (state_q == RUN) || (state_q == WAIT_BND);
  assign warm_last = 8'(Q) * 8'(cic_r_q) - 8'd1;

  assign cfg_ready = (state_q == RUN);
  assign cfg_err   = cfg_err_q;
  assign cic_r     = cic_r_q;
  assign cic_rst_n = !in_flush;
  assign busy      = (state_q != RUN);

  cic_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (in_flush),
    .clear   (in_flush),
    .r       (cic_r_q),
    .out_en  (out_en),
    .in_stb  (in_stb),
    .out_stb (out_stb)
  );

  always_comb begin
    state_d     = state_q;
    cic_r_d     = cic_r_q;
    pend_r_d    = pend_r_q;
    flush_cnt_d = flush_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    cfg_err_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_valid) begin
          if (!is_valid_r(cfg_r)) begin
            cfg_err_d = 1'b1;
          end else if (cfg_r != cic_r_q) begin
            pend_r_d = cfg_r;
            state_d  = WAIT_BND;
          end
        end
      end
      WAIT_BND: begin
        // out_stb marks the last output at the old R; flush right after it.
        if (out_stb) begin
          state_d     = FLUSH;
          cic_r_d     = pend_r_q;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 8'(FLUSH_LEN - 1)) begin
          state_d     = WARM;
          flush_cnt_d = '0;
          warm_cnt_d  = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      WARM: begin
        // Q*R input samples refill the integrators; ph_cnt has wrapped to 0
        // by then, so the first RUN output lands on a clean boundary.
        if (in_stb) begin
          if (warm_cnt_q == warm_last) state_d = RUN;
          else                         warm_cnt_d = warm_cnt_q + 8'd1;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      cic_r_q     <= R_W'(1);
      pend_r_q    <= R_W'(1);
      flush_cnt_q <= '0;
      warm_cnt_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cic_r_q     <= cic_r_d;
      pend_r_q    <= pend_r_d;
      flush_cnt_q <= flush_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

`ifdef CIC_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cfg_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
